// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one shift-subtract-restore step per cycle,
// quotient/remainder/div_by_zero returned with a one-cycle done strobe.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] r_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_iter;

    // The partial remainder always stays below the divisor, so its top bit is
    // never needed in storage; only the shifted trial value needs WIDTH+1 bits.
    always_comb begin
        shifted   = {r_r, q_r[WIDTH-1]};
        trial     = shifted - {1'b0, d_r};
        r_nxt     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_nxt     = {q_r[WIDTH-2:0], ~trial[WIDTH]};
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    assign busy = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            q_r         <= '0;
            d_r         <= '0;
            r_r         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            q_r   <= dividend;
                            d_r   <= divisor;
                            r_r   <= '0;
                            cnt   <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                default: begin
                    q_r <= q_nxt;
                    r_r <= r_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient    <= q_nxt;
                        remainder   <= r_nxt;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
